// File: rtl/guess_entry.sv
// guess_entry: player-side guess assembler feeding the grader.
// Collects one shape per slot into Guess, raises GradeIt on Submit and
// clears itself once the grader returns GuessReady.
// Optional feature macro: GUESS_DUP_CHECK_EN rejects a load whose shape
// already sits in another filled slot.
module guess_entry #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SHAPE_W   = 3,
  parameter int unsigned MAX_SHAPE = 5,
  localparam int unsigned GUESS_W  = NUM_SLOTS * SHAPE_W
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 StartGame,
  input  logic [SHAPE_W-1:0]   GuessShape,
  input  logic [1:0]           GuessLocation,
  input  logic                 LoadGuess,
  input  logic                 Submit,
  input  logic                 GuessReady,
  output logic [GUESS_W-1:0]   Guess,
  output logic                 GradeIt,
  output logic [NUM_SLOTS-1:0] slotsFilled,
  output logic                 busy,
  output logic                 EntryError
);

  // One extra bit so out-of-range slot indices are representable.
  localparam int unsigned LOC_W = $clog2(NUM_SLOTS) + 1;

  typedef enum logic [1:0] {IDLE, ENTER, GRADE} entryState;

  entryState            state;
  entryState            nextState;
  logic [LOC_W-1:0]     locExt;
  logic                 locOk;
  logic                 shapeOk;
  logic                 dupHit;
  logic                 loadOk;
  logic                 allFilled;
  logic [GUESS_W-1:0]   guessNext;
  logic [NUM_SLOTS-1:0] filledNext;
  logic                 errNext;

  assign locExt    = LOC_W'(GuessLocation);
  assign locOk     = locExt < LOC_W'(NUM_SLOTS);
  assign shapeOk   = GuessShape <= SHAPE_W'(MAX_SHAPE);
  assign allFilled = &slotsFilled;
  assign loadOk    = locOk && shapeOk && !dupHit;

`ifdef GUESS_DUP_CHECK_EN
  // Flag a shape already present in a different filled slot.
  always_comb begin
    dupHit = 1'b0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (slotsFilled[i] && (LOC_W'(i) != locExt) &&
          (Guess[SHAPE_W*i +: SHAPE_W] == GuessShape)) begin
        dupHit = 1'b1;
      end
    end
  end
`else
  assign dupHit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; StartGame low wins over everything but reset.
  always_comb begin
    nextState = state;
    if (!StartGame) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    nextState = ENTER;
        ENTER:   if (!LoadGuess && Submit && allFilled) nextState = GRADE;
        GRADE:   if (GuessReady) nextState = ENTER;
        default: nextState = IDLE;
      endcase
    end
  end

  // Next values of the guess word, slot flags and error pulse.
  always_comb begin
    guessNext  = Guess;
    filledNext = slotsFilled;
    errNext    = 1'b0;
    if (!StartGame) begin
      guessNext  = '0;
      filledNext = '0;
    end else begin
      case (state)
        ENTER: begin
          if (LoadGuess) begin
            if (loadOk) begin
              for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                if (LOC_W'(i) == locExt) begin
                  guessNext[SHAPE_W*i +: SHAPE_W] = GuessShape;
                  filledNext[i]                   = 1'b1;
                end
              end
            end else begin
              errNext = 1'b1;
            end
          end else if (Submit && !allFilled) begin
            errNext = 1'b1;
          end
        end
        GRADE: begin
          if (GuessReady) begin
            guessNext  = '0;
            filledNext = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; GradeIt and busy mirror the GRADE state.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      Guess       <= '0;
      slotsFilled <= '0;
      GradeIt     <= 1'b0;
      busy        <= 1'b0;
      EntryError  <= 1'b0;
    end else begin
      Guess       <= guessNext;
      slotsFilled <= filledNext;
      GradeIt     <= (nextState == GRADE);
      busy        <= (nextState == GRADE);
      EntryError  <= errNext;
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Directed self-checking bench for guess_entry.
// Honours GUESS_DUP_CHECK_EN when choosing the duplicate-load expectation.
module tb_guess_entry;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        StartGame;
  logic [2:0]  GuessShape;
  logic [1:0]  GuessLocation;
  logic        LoadGuess;
  logic        Submit;
  logic        GuessReady;
  logic [11:0] Guess;
  logic        GradeIt;
  logic [3:0]  slotsFilled;
  logic        busy;
  logic        EntryError;

  int assertCount = 0;
  int failCount   = 0;

  guess_entry dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .StartGame     (StartGame),
    .GuessShape    (GuessShape),
    .GuessLocation (GuessLocation),
    .LoadGuess     (LoadGuess),
    .Submit        (Submit),
    .GuessReady    (GuessReady),
    .Guess         (Guess),
    .GradeIt       (GradeIt),
    .slotsFilled   (slotsFilled),
    .busy          (busy),
    .EntryError    (EntryError)
  );

  // 50 MHz-style free-running clock.
  always #5 CLOCK_50 = ~CLOCK_50;

  // Count one comparison and report it if it differs.
  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then stable until the next edge.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One-cycle LoadGuess strobe, optionally with Submit in the same cycle.
  task automatic load(input logic [1:0] loc, input logic [2:0] shape, input logic withSubmit);
    GuessLocation = loc;
    GuessShape    = shape;
    LoadGuess     = 1'b1;
    Submit        = withSubmit;
    step();
    LoadGuess     = 1'b0;
    Submit        = 1'b0;
  endtask

  task automatic submit();
    Submit = 1'b1;
    step();
    Submit = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; StartGame = 1'b1; GuessShape = 3'd1; GuessLocation = 2'd0;
    LoadGuess = 1'b1; Submit = 1'b0; GuessReady = 1'b0;

    // Reset holds despite StartGame and LoadGuess being active.
    step();
    step();
    checkValue("rst_guess", 32'(Guess), 32'h0);
    checkValue("rst_filled", 32'(slotsFilled), 32'h0);
    checkValue("rst_gradeit", 32'(GradeIt), 32'h0);
    checkValue("rst_err", 32'(EntryError), 32'h0);
    checkValue("rst_busy", 32'(busy), 32'h0);
    LoadGuess = 1'b0;
    reset     = 1'b1;
    step();                                   // IDLE -> ENTER

    // Fill all slots and submit.
    load(2'd0, 3'd1, 1'b0);
    load(2'd1, 3'd2, 1'b0);
    load(2'd2, 3'd3, 1'b0);
    load(2'd3, 3'd4, 1'b0);
    checkValue("fill_guess", 32'(Guess), 32'h8D1);
    checkValue("fill_filled", 32'(slotsFilled), 32'hF);
    checkValue("fill_gradeit_low", 32'(GradeIt), 32'h0);
    submit();
    checkValue("sub_gradeit", 32'(GradeIt), 32'h1);
    checkValue("sub_busy", 32'(busy), 32'h1);
    step();
    checkValue("sub_gradeit_held", 32'(GradeIt), 32'h1);
    checkValue("sub_guess_held", 32'(Guess), 32'h8D1);
    GuessReady = 1'b1;
    step();
    GuessReady = 1'b0;
    checkValue("rdy_gradeit", 32'(GradeIt), 32'h0);
    checkValue("rdy_busy", 32'(busy), 32'h0);
    checkValue("rdy_guess", 32'(Guess), 32'h0);
    checkValue("rdy_filled", 32'(slotsFilled), 32'h0);

    // Early submit with only slots 0 and 2 loaded.
    load(2'd0, 3'd1, 1'b0);
    load(2'd2, 3'd3, 1'b0);
    submit();
    checkValue("early_err", 32'(EntryError), 32'h1);
    checkValue("early_gradeit", 32'(GradeIt), 32'h0);
    checkValue("early_filled", 32'(slotsFilled), 32'h5);
    step();
    checkValue("early_err_pulse", 32'(EntryError), 32'h0);

    // Illegal shape is rejected; MAX_SHAPE itself is legal.
    load(2'd1, 3'd6, 1'b0);
    checkValue("bad_err", 32'(EntryError), 32'h1);
    checkValue("bad_filled", 32'(slotsFilled), 32'h5);
    checkValue("bad_guess", 32'(Guess), 32'h0C1);
    load(2'd1, 3'd5, 1'b0);
    checkValue("max_err", 32'(EntryError), 32'h0);
    checkValue("max_filled", 32'(slotsFilled), 32'h7);
    load(2'd3, 3'd0, 1'b0);
    checkValue("zero_guess", 32'(Guess), 32'h0E9);
    submit();
    checkValue("sub2_gradeit", 32'(GradeIt), 32'h1);

    // Loads and submits in GRADE are ignored without error.
    load(2'd0, 3'd2, 1'b0);
    checkValue("grade_load_guess", 32'(Guess), 32'h0E9);
    checkValue("grade_load_err", 32'(EntryError), 32'h0);
    submit();
    checkValue("grade_sub_err", 32'(EntryError), 32'h0);
    checkValue("grade_sub_gradeit", 32'(GradeIt), 32'h1);

    // Abort from GRADE by dropping StartGame.
    StartGame = 1'b0;
    step();
    checkValue("abort_gradeit", 32'(GradeIt), 32'h0);
    checkValue("abort_guess", 32'(Guess), 32'h0);
    checkValue("abort_filled", 32'(slotsFilled), 32'h0);
    checkValue("abort_busy", 32'(busy), 32'h0);
    StartGame = 1'b1;
    load(2'd0, 3'd1, 1'b0);                   // state is IDLE: ignored
    checkValue("idle_load_filled", 32'(slotsFilled), 32'h0);
    checkValue("idle_load_err", 32'(EntryError), 32'h0);

    // GuessReady outside GRADE is ignored.
    load(2'd0, 3'd1, 1'b0);
    load(2'd1, 3'd2, 1'b0);
    load(2'd2, 3'd3, 1'b0);
    GuessReady = 1'b1;
    step();
    GuessReady = 1'b0;
    checkValue("enter_rdy_filled", 32'(slotsFilled), 32'h7);

    // Load + Submit together completing the guess: load wins, Submit dropped.
    load(2'd3, 3'd4, 1'b1);
    checkValue("ls_filled", 32'(slotsFilled), 32'hF);
    checkValue("ls_guess", 32'(Guess), 32'h8D1);
    checkValue("ls_gradeit", 32'(GradeIt), 32'h0);
    checkValue("ls_err", 32'(EntryError), 32'h0);

    // GuessReady already high on the first GRADE cycle.
    submit();
    checkValue("fast_gradeit", 32'(GradeIt), 32'h1);
    GuessReady = 1'b1;
    step();
    GuessReady = 1'b0;
    checkValue("fast_gradeit_drop", 32'(GradeIt), 32'h0);
    checkValue("fast_filled", 32'(slotsFilled), 32'h0);

    // Reset in the middle of GRADE.
    load(2'd0, 3'd1, 1'b0);
    load(2'd1, 3'd2, 1'b0);
    load(2'd2, 3'd3, 1'b0);
    load(2'd3, 3'd4, 1'b0);
    submit();
    checkValue("pre_rst_gradeit", 32'(GradeIt), 32'h1);
    doReset();
    checkValue("mid_rst_gradeit", 32'(GradeIt), 32'h0);
    checkValue("mid_rst_guess", 32'(Guess), 32'h0);
    step();                                   // IDLE -> ENTER

    // Duplicate shapes in different slots.
    load(2'd0, 3'd2, 1'b0);
    load(2'd0, 3'd2, 1'b0);                   // same slot rewrite is always fine
    checkValue("rewrite_err", 32'(EntryError), 32'h0);
    load(2'd1, 3'd2, 1'b0);
`ifdef GUESS_DUP_CHECK_EN
    checkValue("dup_filled", 32'(slotsFilled), 32'h1);
    checkValue("dup_err", 32'(EntryError), 32'h1);
`else
    checkValue("dup_filled", 32'(slotsFilled), 32'h3);
    checkValue("dup_err", 32'(EntryError), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
